// File: rtl/dsc_mul_k.sv
// dsc_mul_k: deterministic stochastic-computing K-operand multiplier.
// Unary streams from a clock-division counter chain are ANDed and counted.
module dsc_mul_k #(
  parameter int W          = 4,
  parameter int K          = 3,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W*K-1:0] ops,
  output logic           busy,
  output logic           done,
  output logic [W*K-1:0] z,
  output logic [W*K:0]   cycles
);

  localparam int N = W * K;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [K-1:0][W-1:0] opv_t;

  state_t       state_q;
  state_t       state_d;
  opv_t         x_q;
  opv_t         x_d;
  opv_t         ctr_q;
  opv_t         ctr_d;
  logic [N-1:0] acc_q;
  logic [N-1:0] acc_d;
  logic [N-1:0] z_d;
  logic [N:0]   cnt_q;
  logic [N:0]   cnt_d;
  logic [N:0]   cyc_d;
  logic         done_d;

  logic [K-1:0] s;
  logic [K-1:0] ones;
  logic [K-1:0] carry;
  logic [K-1:0] zero;
  logic         p;
  logic         hit;
  logic         last;

  // carry[i]: every lower counter sits at all-ones
  always_comb begin
    logic c;
    c     = 1'b1;
    s     = '0;
    ones  = '0;
    zero  = '0;
    carry = '0;
    for (int i = 0; i < K; i++) begin
      s[i]     = ctr_q[i] < x_q[i];
      ones[i]  = &ctr_q[i];
      zero[i]  = x_q[i] == '0;
      carry[i] = c;
      c        = c & ones[i];
    end
  end

  assign p   = &s;
  assign hit = carry[K-1]
             & (ctr_q[K-1] == x_q[K-1] - W'(1));

  // past the top stream's last one, nothing more can be counted
  assign last = EARLY_TERM ? (|zero | hit) : &ones;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ctr_d   = ctr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    z_d     = z;
    cyc_d   = cycles;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = ops;
          ctr_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = acc_q + N'(p);
        cnt_d = cnt_q + (N+1)'(1);
        for (int i = 0; i < K; i++) begin
          if (carry[i]) begin
            ctr_d[i] = ctr_q[i] + W'(1);
          end
        end
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          z_d     = acc_d;
          cyc_d   = cnt_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      ctr_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      z       <= '0;
      cycles  <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ctr_q   <= ctr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      z       <= z_d;
      cycles  <= cyc_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_dsc_mul_k.sv
// tb_dsc_mul_k: four parameterisations checked against a run-length model.
// Directed vectors plus literal expectations on product and run length.
module tb_dsc_mul_k;

  localparam int PW[4] = '{4, 4, 8, 2};
  localparam int PK[4] = '{3, 3, 2, 4};
  localparam int PE[4] = '{1, 0, 1, 1};

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       start = '0;
  logic [3:0][19:0] opsv = '0;
  logic [3:0]       busy_v;
  logic [3:0]       done_v;
  logic [11:0]      z_a;
  logic [11:0]      z_b;
  logic [15:0]      z_c;
  logic [7:0]       z_d;
  logic [12:0]      cy_a;
  logic [12:0]      cy_b;
  logic [16:0]      cy_c;
  logic [8:0]       cy_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsc_mul_k #(.W(4), .K(3), .EARLY_TERM(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(start[0]),
    .ops(opsv[0][11:0]), .busy(busy_v[0]),
    .done(done_v[0]), .z(z_a), .cycles(cy_a)
  );
  dsc_mul_k #(.W(4), .K(3), .EARLY_TERM(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(start[1]),
    .ops(opsv[1][11:0]), .busy(busy_v[1]),
    .done(done_v[1]), .z(z_b), .cycles(cy_b)
  );
  dsc_mul_k #(.W(8), .K(2), .EARLY_TERM(1'b1)) u_c (
    .clk(clk), .rst(rst), .start(start[2]),
    .ops(opsv[2][15:0]), .busy(busy_v[2]),
    .done(done_v[2]), .z(z_c), .cycles(cy_c)
  );
  dsc_mul_k #(.W(2), .K(4), .EARLY_TERM(1'b1)) u_d (
    .clk(clk), .rst(rst), .start(start[3]),
    .ops(opsv[3][7:0]), .busy(busy_v[3]),
    .done(done_v[3]), .z(z_d), .cycles(cy_d)
  );

  function automatic logic [63:0] zget(input int i);
    case (i)
      0: return 64'(z_a);
      1: return 64'(z_b);
      2: return 64'(z_c);
      default: return 64'(z_d);
    endcase
  endfunction

  function automatic logic [63:0] cget(input int i);
    case (i)
      0: return 64'(cy_a);
      1: return 64'(cy_b);
      2: return 64'(cy_c);
      default: return 64'(cy_d);
    endcase
  endfunction

  typedef struct {
    bit     busy;
    bit     done;
    longint rem;
    longint z;
    longint cyc;
    longint prod;
    longint len;
  } mdl_t;

  mdl_t mdl[4];

  // product and run length straight from the operand values
  function automatic mdl_t step(input mdl_t m, input int i,
                                input logic st,
                                input logic [19:0] o);
    mdl_t   n;
    longint v;
    longint pr;
    longint top;
    bit     zr;
    n = m;
    n.done = 1'b0;
    if (m.busy) begin
      n.rem = m.rem - 1;
      if (n.rem == 0) begin
        n.busy = 1'b0;
        n.done = 1'b1;
        n.z = m.prod;
        n.cyc = m.len;
      end
    end else if (st) begin
      pr = 1;
      zr = 1'b0;
      top = 0;
      for (int k = 0; k < PK[i]; k++) begin
        v = longint'((o >> (k * PW[i])) & ((20'd1 << PW[i]) - 20'd1));
        pr = pr * v;
        if (v == 0) zr = 1'b1;
        top = v;
      end
      n.prod = pr;
      if (PE[i] == 0)
        n.len = longint'(1) << (PW[i] * PK[i]);
      else if (zr)
        n.len = 1;
      else
        n.len = top * (longint'(1) << (PW[i] * (PK[i] - 1)));
      n.busy = 1'b1;
      n.rem = n.len;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst)
        mdl[i] <= '{default: 0};
      else
        mdl[i] <= step(mdl[i], i, start[i], opsv[i]);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d.busy", i), 64'(busy_v[i]), 64'(mdl[i].busy));
      chk($sformatf("u%0d.done", i), 64'(done_v[i]), 64'(mdl[i].done));
      chk($sformatf("u%0d.z", i), zget(i), 64'(mdl[i].z));
      chk($sformatf("u%0d.cycles", i), cget(i), 64'(mdl[i].cyc));
    end
  end

  task automatic wait_done(input int i, input int budget,
                           output int nbusy);
    int n;
    bit fin;
    n = 0;
    fin = 1'b0;
    nbusy = 0;
    while (!fin) begin
      @(negedge clk);
      if (done_v[i] === 1'b1) begin
        fin = 1'b1;
      end else begin
        if (busy_v[i] === 1'b1) nbusy++;
        n++;
        if (n > budget) begin
          failures++;
          checks++;
          $display("FAIL u%0d.timeout actual=%0d required=done", i, n);
          fin = 1'b1;
        end
      end
    end
  endtask

  task automatic run(input int i, input logic [19:0] o,
                     input int budget, output int nbusy);
    @(posedge clk);
    #2;
    opsv[i] = o;
    start[i] = 1'b1;
    @(posedge clk);
    #2;
    start[i] = 1'b0;
    wait_done(i, budget, nbusy);
  endtask

  initial begin
    int nb0;
    int nb1;
    logic [19:0] o;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy_v[0]), 0);
    chk("rst.done", 64'(done_v[0]), 0);
    chk("rst.z", zget(0), 0);
    chk("rst.cycles", cget(0), 0);
    @(negedge clk);
    #2 rst = 1'b1;

    fork
      run(0, 20'({4'd15, 4'd15, 4'd15}), 5000, nb0);
      run(1, 20'({4'd15, 4'd15, 4'd15}), 5000, nb1);
    join
    chk("basic.z", zget(0), 3375);
    chk("basic.cycles", cget(0), 3840);
    chk("basic.mdl_z", 64'(mdl[0].z), 3375);
    chk("basic.mdl_cyc", 64'(mdl[0].cyc), 3840);
    chk("full.z", zget(1), 3375);
    chk("full.cycles", cget(1), 4096);
    chk("full.busy_cycles", 64'(nb1), 4096);
    @(negedge clk);
    chk("basic.single_done", 64'(done_v[0]), 0);

    fork
      run(0, 20'({4'd9, 4'd0, 4'd3}), 10, nb0);
      run(1, 20'({4'd9, 4'd0, 4'd3}), 5000, nb1);
    join
    chk("zero_et.z", zget(0), 0);
    chk("zero_et.cycles", cget(0), 1);
    chk("zero_full.z", zget(1), 0);
    chk("zero_full.cycles", cget(1), 4096);

    @(posedge clk);
    #2;
    opsv[0] = 20'({4'd7, 4'd5, 4'd3});
    start[0] = 1'b1;
    @(posedge clk);
    #2;
    start[0] = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    opsv[0] = 20'({4'd15, 4'd15, 4'd15});
    start[0] = 1'b1;
    @(posedge clk);
    #2;
    start[0] = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    opsv[0] = 20'({4'd2, 4'd3, 4'd5});
    start[0] = 1'b1;
    wait_done(0, 2000, nb0);
    chk("hs.z", zget(0), 105);
    chk("hs.cycles", cget(0), 1792);
    @(posedge clk);
    #2;
    start[0] = 1'b0;
    @(negedge clk);
    chk("b2b.busy", 64'(busy_v[0]), 1);
    wait_done(0, 1000, nb0);
    chk("b2b.z", zget(0), 30);
    chk("b2b.cycles", cget(0), 512);

    @(posedge clk);
    #2;
    opsv[0] = 20'({4'd15, 4'd15, 4'd15});
    start[0] = 1'b1;
    @(posedge clk);
    #2;
    start[0] = 1'b0;
    repeat (50) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst.busy", 64'(busy_v[0]), 0);
    chk("mid_rst.done", 64'(done_v[0]), 0);
    chk("mid_rst.z", zget(0), 0);
    chk("mid_rst.cycles", cget(0), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (20) @(posedge clk);
    run(0, 20'({4'd7, 4'd5, 4'd3}), 2000, nb0);
    chk("post_rst.z", zget(0), 105);
    chk("post_rst.cycles", cget(0), 1792);

    run(2, 20'({8'd100, 8'd200}), 26000, nb0);
    chk("w8.z", zget(2), 20000);
    chk("w8.cycles", cget(2), 25600);

    fork
      begin
        for (int r = 0; r < 100; r++) begin
          logic [19:0] oc;
          int nbc;
          oc = '0;
          oc[7:0] = 8'($urandom_range(0, 255));
          oc[15:8] = 8'($urandom_range(0, 2));
          run(2, oc, 800, nbc);
        end
      end
      begin
        for (int r = 0; r < 100; r++) begin
          logic [19:0] od;
          int nbd;
          od = '0;
          od[7:0] = 8'($urandom_range(0, 255));
          run(3, od, 300, nbd);
        end
      end
    join

    o = 20'({2'd3, 2'd2, 2'd3, 2'd1});
    run(3, o, 300, nb0);
    chk("w2.z", zget(3), 18);
    chk("w2.cycles", cget(3), 192);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
